// File: rtl/dsp_addsub_pipe.sv
// dsp_addsub_pipe
//   Two-stage pipelined add / subtract / accumulate unit. The carry chain is
//   split at HALF = WIDTH/2: stage 1 registers the low-half sum and its carry
//   together with the high halves of the effective operands. Stage 2 (the
//   output register) finishes the high half and forms the flags.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand beat handshake
//   in_op            00 ADD, 01 SUB, 10 ACC (acc_q + a), 11 LOAD (acc_q <= a)
//   in_a, in_b       operands (in_b unused for ACC and LOAD)
//   out_valid/ready  result handshake
//   out_data         result, modulo 2^WIDTH
//   out_carry        carry out of the MSB (SUB: 1 = no borrow)
//   out_ovf          signed overflow
//   acc_q            current accumulator value
//
// Handshake: a beat moves on an edge where valid && ready are both high.
// A producer holds valid and its payload until that edge. in_ready is a
// function of internal state and out_ready only. out_* stay stable while
// out_valid && !out_ready.
module dsp_addsub_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [WIDTH-1:0] acc_q
);

   localparam int HALF = WIDTH / 2;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic [HALF-1:0]  s1_lo_q, s1_lo_d;
   logic             s1_lo_c_q, s1_lo_c_d;
   logic [HALF-1:0]  s1_xh_q, s1_xh_d;
   logic [HALF-1:0]  s1_yh_q, s1_yh_d;

   // Stage 2 (output) state
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_carry_q, out_carry_d;
   logic             out_ovf_q, out_ovf_d;
   logic [WIDTH-1:0] acc_d;

   logic             s1_load, s2_load;
   logic             s1_acc_like;
   logic [WIDTH-1:0] x_eff, y_eff;
   logic             cin;
   logic [HALF:0]    lo_sum;
   logic [HALF:0]    hi_sum;
   logic [WIDTH-1:0] res_data;
   logic             res_carry, res_ovf;

   // ACC and LOAD both write acc_q; op[1] marks them.
   assign s1_acc_like = s1_valid_q && s1_op_q[1];

   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   // An ACC/LOAD in stage 1 blocks all new beats, so a following ACC always
   // reads acc_q after that op's result has been written.
   assign in_ready = (!s1_valid_q || s2_load) && !s1_acc_like;
   assign s1_load  = in_valid && in_ready;

   // Effective adder inputs. For LOAD, y = 0 and cin = 0, so the sum is in_a.
   always_comb begin
      x_eff = in_a;
      y_eff = in_b;
      cin   = 1'b0;
      case (in_op)
         OP_SUB: begin
            y_eff = ~in_b;
            cin   = 1'b1;
         end
         OP_ACC: begin
            x_eff = acc_q;
            y_eff = in_a;
         end
         OP_LOAD: y_eff = '0;
         default: ;
      endcase
      lo_sum = {1'b0, x_eff[HALF-1:0]} + {1'b0, y_eff[HALF-1:0]}
             + {{HALF{1'b0}}, cin};
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_lo_d    = s1_lo_q;
      s1_lo_c_d  = s1_lo_c_q;
      s1_xh_d    = s1_xh_q;
      s1_yh_d    = s1_yh_q;
      if (s1_load) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_lo_d    = lo_sum[HALF-1:0];
         s1_lo_c_d  = lo_sum[HALF];
         s1_xh_d    = x_eff[WIDTH-1:HALF];
         s1_yh_d    = y_eff[WIDTH-1:HALF];
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   // High half completes with the registered low carry.
   always_comb begin
      hi_sum    = {1'b0, s1_xh_q} + {1'b0, s1_yh_q} + {{HALF{1'b0}}, s1_lo_c_q};
      res_data  = {hi_sum[HALF-1:0], s1_lo_q};
      res_carry = hi_sum[HALF];
      res_ovf   = (s1_xh_q[HALF-1] == s1_yh_q[HALF-1]) &&
                  (hi_sum[HALF-1] != s1_xh_q[HALF-1]);
      if (s1_op_q == OP_LOAD) begin
         res_carry = 1'b0;
         res_ovf   = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      out_ovf_d   = out_ovf_q;
      acc_d       = acc_q;
      if (s2_load) begin
         out_valid_d = 1'b1;
         out_data_d  = res_data;
         out_carry_d = res_carry;
         out_ovf_d   = res_ovf;
         if (s1_op_q[1]) begin
            acc_d = res_data;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_ADD;
         s1_lo_q     <= '0;
         s1_lo_c_q   <= 1'b0;
         s1_xh_q     <= '0;
         s1_yh_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_ovf_q   <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_lo_q     <= s1_lo_d;
         s1_lo_c_q   <= s1_lo_c_d;
         s1_xh_q     <= s1_xh_d;
         s1_yh_q     <= s1_yh_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
         out_ovf_q   <= out_ovf_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_ovf   = out_ovf_q;

endmodule
